bcd_digit_sequencer: RTL and testbench
======================================

// Module: bcd_digit_sequencer
// PURPOSE
//  Timed source of 4-bit BCD digits for the combinational minimization stage.
//  digit[3] drives i3 and digit[0] drives i0.
//  Steps 0..LAST_DIGIT every PRESCALE clocks and counts complete sweeps.
//  Supports run/hold/stop control and a synchronous digit load.
//  Replaces the free-running stimulus loop with a reusable clocked driver.
// PARAMETERS
//  PRESCALE    10  clocks per digit step; legal range >=1
//  LAST_DIGIT  9   highest digit emitted; legal range 1..15
//  SWEEPS      1   full sweeps before DONE; 0 = run endlessly
// PORTS
//  clk     in   1  single clock, rising edge
//  rst     in   1  asynchronous, active-high reset
//  start   in   1  level-sampled; starts or resumes sequencing
//  stop    in   1  level-sampled; pauses, or aborts when already paused
//  ld      in   1  synchronous digit load
//  ld_val  in   4  value loaded when ld=1
//  digit   out  4  registered digit {i3,i2,i1,i0} for the downstream stage
//  valid   out  1  digit meaningful (state != IDLE)
//  busy    out  1  state == RUN
//  done    out  1  state == DONE
//  wrap    out  1  one-cycle pulse on every end-of-sweep step
// BEHAVIOUR
//  Reset: state=IDLE, digit=0, valid=0, busy=0, done=0, wrap=0.
//   Prescaler and sweep counters are also cleared.
//  FSM states are IDLE, RUN, HOLD and DONE. All outputs are registered.
//   IDLE: start -> RUN. Prescaler and sweep count cleared; digit kept.
//   RUN: stop -> HOLD. Prescaler frozen; digit kept.
//   RUN: the final sweep completes -> DONE.
//   HOLD: start -> RUN, resuming with the prescaler value preserved.
//   HOLD: stop -> IDLE with digit=0.
//   DONE: start -> RUN with digit=0 and counters cleared.
//   DONE: stop -> IDLE with digit=0.
//  Priority: stop beats start when both are high in the same cycle.
//  Prescaler: counts 0..PRESCALE-1, and only while in RUN.
//   A tick occurs in a RUN cycle where the prescaler equals PRESCALE-1.
//  Latency: start sampled at edge n gives RUN and busy=1 after edge n.
//   digit first changes at edge n+1+PRESCALE.
//   With PRESCALE=1, digit steps on every edge while in RUN.
//  Step on tick: digit+1.
//   At digit==LAST_DIGIT, digit goes to 0, wrap=1 for one cycle, sweep count +1.
//   If that step completes sweep SWEEPS (SWEEPS!=0), enter DONE instead.
//   On entering DONE, digit holds LAST_DIGIT, wrap=1 and done=1.
//  Sweep counter is 8 bits wide. With SWEEPS=0 it is not compared and wraps freely.
//  ld: accepted in any state.
//   digit <= ld_val, or 0 if ld_val>LAST_DIGIT; prescaler cleared.
//   State and sweep count are unchanged.
//  ld together with a tick: ld wins, so no step and no wrap that cycle.
//  ld together with stop/start: both take effect; ld sets the digit.
//   Exception: when stop moves the block to IDLE, digit=0 takes precedence over ld.
//  rst mid-run: all outputs return to their reset values immediately, without a clock.
// CONFIGURATION
//  Macro DOWN_COUNT_EN:
//   Defined: adds input port dir (1 bit). dir=1 makes a tick decrement.
//    0 -> LAST_DIGIT counts as the end-of-sweep step (wrap, sweep +1).
//    The final sweep enters DONE holding digit=0.
//    DONE->RUN via start reloads digit=LAST_DIGIT when dir=1.
//    dir is sampled on every tick, so direction may change mid-sweep.
//   Undefined: no dir port; the block counts up only, as described above.
// TESTING
//  1. PRESCALE=1, SWEEPS=1, pulse start -> digit 0,1..9 on consecutive edges.
//     wrap=1 and done=1 with digit=9; busy=0 afterwards.
//  2. PRESCALE=3: start at edge 0 -> digit=1 after edge 4, digit=2 after edge 7.
//  3. In RUN at digit=4, assert stop for one cycle -> HOLD, digit stays 4.
//     Then assert start -> resumes and steps to 5 on the tick.
//  4. ld=1 with ld_val=12 while in RUN -> digit=0 and the prescaler restarts.
//     ld_val=7 in the same cycle as a tick -> digit=7 and wrap=0.
//  5. Assert rst mid-sweep at digit=6 -> digit=0 and valid=0 before the next edge.
//     start and stop high together in IDLE -> block stays in IDLE.
//  6. DOWN_COUNT_EN, dir=1, PRESCALE=1, SWEEPS=2, start from DONE.
//     -> digit 9..0, wrap, 9..0, then done=1 with digit=0.

Source files
------------

// File: rtl/bcd_digit_sequencer_if.sv
// Control and digit bus of bcd_digit_sequencer; the sequencer sits on the slave side.
// DOWN_COUNT_EN adds the dir control line.
interface bcd_digit_sequencer_if;
  logic       start;
  logic       stop;
  logic       ld;
  logic [3:0] ld_val;
`ifdef DOWN_COUNT_EN
  logic       dir;
`endif
  logic [3:0] digit;
  logic       valid;
  logic       busy;
  logic       done;
  logic       wrap;

  modport master (
`ifdef DOWN_COUNT_EN
    output dir,
`endif
    output start, stop, ld, ld_val,
    input  digit, valid, busy, done, wrap
  );

  modport slave (
`ifdef DOWN_COUNT_EN
    input  dir,
`endif
    input  start, stop, ld, ld_val,
    output digit, valid, busy, done, wrap
  );
endinterface

// File: rtl/bcd_digit_sequencer.sv
// Timed BCD digit source stepping 0..LAST_DIGIT every PRESCALE clocks; DOWN_COUNT_EN adds a dir port.
// Latency: busy one edge after start, first step PRESCALE+1 edges later, then one step per PRESCALE edges.
// Backpressure: none; stop pauses in place (HOLD) and a second stop aborts to IDLE.
module bcd_digit_sequencer #(
  parameter int PRESCALE   = 10,
  parameter int LAST_DIGIT = 9,
  parameter int SWEEPS     = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  bcd_digit_sequencer_if.slave bus
);
  localparam int              PW         = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0]   PRESC_MAX  = PW'(PRESCALE - 1);
  localparam logic [3:0]      LAST       = 4'(LAST_DIGIT);
  localparam logic [7:0]      SWEEP_GOAL = 8'(SWEEPS);
  localparam bit              ENDLESS    = (SWEEPS == 0);

  typedef enum logic [1:0] {IDLE, RUN, HOLD, DONE} state_t;

  state_t        state_q, state_nxt;
  logic [PW-1:0] presc_q, presc_nxt;
  logic          tick_q, tick_nxt;
  logic [7:0]    sweep_q, sweep_nxt;
  logic [3:0]    digit_q, digit_nxt;
  logic          wrap_q, wrap_nxt;
  logic          valid_q, busy_q, done_q;
  logic          step, at_end, abort, down;
  logic [3:0]    ld_dig;

`ifdef DOWN_COUNT_EN
  assign down = bus.dir;
`else
  assign down = 1'b0;
`endif

  assign ld_dig = (bus.ld_val > LAST) ? 4'd0 : bus.ld_val;

  // tick_q is the registered prescaler carry; the step itself happens on the
  // following RUN edge, which gives the extra cycle of start-to-step latency.
  always_comb begin
    state_nxt = state_q;
    presc_nxt = presc_q;
    tick_nxt  = tick_q;
    sweep_nxt = sweep_q;
    digit_nxt = digit_q;
    wrap_nxt  = 1'b0;
    step      = 1'b0;
    at_end    = 1'b0;
    abort     = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && !bus.stop) begin
          state_nxt = RUN;
          presc_nxt = '0;
          tick_nxt  = 1'b0;
          sweep_nxt = '0;
        end
      end
      RUN: begin
        if (bus.stop) begin
          state_nxt = HOLD;
        end else begin
          presc_nxt = (presc_q == PRESC_MAX) ? '0 : presc_q + 1'b1;
          tick_nxt  = (presc_q == PRESC_MAX);
          step      = tick_q && !bus.ld;
        end
      end
      HOLD: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          digit_nxt = 4'd0;
          presc_nxt = '0;
          tick_nxt  = 1'b0;
          abort     = 1'b1;
        end else if (bus.start) begin
          state_nxt = RUN;
        end
      end
      DONE: begin
        if (bus.stop) begin
          state_nxt = IDLE;
          digit_nxt = 4'd0;
          abort     = 1'b1;
        end else if (bus.start) begin
          state_nxt = RUN;
          digit_nxt = down ? LAST : 4'd0;
          presc_nxt = '0;
          tick_nxt  = 1'b0;
          sweep_nxt = '0;
        end
      end
      default: state_nxt = IDLE;
    endcase

    if (step) begin
      at_end = down ? (digit_q == 4'd0) : (digit_q == LAST);
      if (at_end) begin
        wrap_nxt  = 1'b1;
        sweep_nxt = sweep_q + 8'd1;
        if (!ENDLESS && (sweep_q + 8'd1 == SWEEP_GOAL))
          state_nxt = DONE;
        else
          digit_nxt = down ? LAST : 4'd0;
      end else begin
        digit_nxt = down ? digit_q - 4'd1 : digit_q + 4'd1;
      end
    end

    // A load restarts the prescaler; only an abort to IDLE overrides its digit.
    if (bus.ld) begin
      presc_nxt = '0;
      tick_nxt  = 1'b0;
      if (!abort)
        digit_nxt = ld_dig;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      presc_q <= '0;
      tick_q  <= 1'b0;
      sweep_q <= '0;
      digit_q <= 4'd0;
      wrap_q  <= 1'b0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_nxt;
      presc_q <= presc_nxt;
      tick_q  <= tick_nxt;
      sweep_q <= sweep_nxt;
      digit_q <= digit_nxt;
      wrap_q  <= wrap_nxt;
      valid_q <= (state_nxt != IDLE);
      busy_q  <= (state_nxt == RUN);
      done_q  <= (state_nxt == DONE);
    end
  end

  assign bus.digit = digit_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.done  = done_q;
  assign bus.wrap  = wrap_q;
endmodule

// File: tb/tb_bcd_digit_sequencer.sv
// Bench for bcd_digit_sequencer: directed scenarios plus random control traffic on
// two instances (PRESCALE=1/SWEEPS=1 and PRESCALE=3/SWEEPS=2) against a countdown model.
module tb_bcd_digit_sequencer;
  localparam int PA = 1, SA = 1, PB = 3, SB = 2, L = 9;
  localparam int S_IDLE = 0, S_RUN = 1, S_HOLD = 2, S_DONE = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   total = 0;
  int   bad = 0;

  bcd_digit_sequencer_if ia ();
  bcd_digit_sequencer_if ib ();

  bcd_digit_sequencer #(.PRESCALE(PA), .LAST_DIGIT(L), .SWEEPS(SA)) u_a (
    .clk(clk), .rst(rst), .bus(ia.slave));
  bcd_digit_sequencer #(.PRESCALE(PB), .LAST_DIGIT(L), .SWEEPS(SB)) u_b (
    .clk(clk), .rst(rst), .bus(ib.slave));

  always #5 clk = ~clk;

  // Reference: wt counts RUN edges remaining until the next digit step.
  typedef struct {
    int st;
    int dig;
    int wt;
    int swp;
    bit wrap;
  } mdl_t;

  function automatic mdl_t mdl_step(mdl_t m, bit start, bit stop, bit ld, int ldv,
                                    bit dir, int p, int last, int goal);
    mdl_t n;
    bit   aborted;
    bit   eos;
    n = m;
    n.wrap = 1'b0;
    aborted = 1'b0;
    eos = 1'b0;
    case (m.st)
      S_IDLE: if (start && !stop) begin n.st = S_RUN; n.wt = p + 1; n.swp = 0; end
      S_RUN: begin
        if (stop) n.st = S_HOLD;
        else if (!ld) begin
          n.wt = m.wt - 1;
          if (n.wt == 0) begin
            n.wt = p;
            eos = dir ? (m.dig == 0) : (m.dig == last);
            if (!eos) n.dig = dir ? m.dig - 1 : m.dig + 1;
            else begin
              n.wrap = 1'b1;
              n.swp = (m.swp + 1) % 256;
              if (goal != 0 && n.swp == goal) n.st = S_DONE;
              else n.dig = dir ? last : 0;
            end
          end
        end
      end
      S_HOLD: begin
        if (stop) begin n.st = S_IDLE; n.dig = 0; aborted = 1'b1; end
        else if (start) n.st = S_RUN;
      end
      S_DONE: begin
        if (stop) begin n.st = S_IDLE; n.dig = 0; aborted = 1'b1; end
        else if (start) begin n.st = S_RUN; n.dig = dir ? last : 0; n.wt = p + 1; n.swp = 0; end
      end
      default: ;
    endcase
    if (ld) begin
      n.wt = p + 1;
      if (!aborted) n.dig = (ldv > last) ? 0 : ldv;
    end
    return n;
  endfunction

  function automatic logic [7:0] mdl_out(mdl_t m);
    return {4'(m.dig), m.st != S_IDLE, m.st == S_RUN, m.st == S_DONE, m.wrap};
  endfunction

  task automatic idle_inputs;
    ia.start = 0; ia.stop = 0; ia.ld = 0; ia.ld_val = 0;
    ib.start = 0; ib.stop = 0; ib.ld = 0; ib.ld_val = 0;
`ifdef DOWN_COUNT_EN
    ia.dir = 0; ib.dir = 0;
`endif
  endtask

  task automatic do_reset;
    idle_inputs();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset;
    logic [7:0] oa, ob;
    idle_inputs();
    rst = 1'b1;
    #1;
    oa = {ia.digit, ia.valid, ia.busy, ia.done, ia.wrap};
    ob = {ib.digit, ib.valid, ib.busy, ib.done, ib.wrap};
    total++; if (oa !== 8'h00) begin bad++; $display("FAIL reset_a got %h want 00", oa); end
    total++; if (ob !== 8'h00) begin bad++; $display("FAIL reset_b got %h want 00", ob); end
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
    oa = {ia.digit, ia.valid, ia.busy, ia.done, ia.wrap};
    total++; if (oa !== 8'h00) begin bad++; $display("FAIL reset_idle_a got %h want 00", oa); end
  endtask

  task automatic test_sweep_p1;
    logic [7:0] oa;
    do_reset();
    ia.start = 1;
    @(negedge clk); ia.start = 0;
    total++; if (ia.busy !== 1'b1 || ia.digit !== 4'd0) begin
      bad++; $display("FAIL sweep_start busy=%b digit=%0d want busy=1 digit=0", ia.busy, ia.digit); end
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk);
      total++; if (ia.digit !== 4'(k) || ia.wrap !== 1'b0) begin
        bad++; $display("FAIL sweep_digit got %0d wrap=%b want %0d wrap=0", ia.digit, ia.wrap, k); end
    end
    @(negedge clk);
    oa = {ia.digit, ia.valid, ia.busy, ia.done, ia.wrap};
    total++; if (oa !== {4'd9, 4'b1011}) begin bad++; $display("FAIL sweep_done got %h want 9b", oa); end
    @(negedge clk);
    oa = {ia.digit, ia.valid, ia.busy, ia.done, ia.wrap};
    total++; if (oa !== {4'd9, 4'b1010}) begin bad++; $display("FAIL sweep_after got %h want 9a", oa); end
  endtask

  task automatic test_latency_p3;
    int expd;
    do_reset();
    ib.start = 1;
    @(negedge clk); ib.start = 0;
    total++; if (ib.busy !== 1'b1) begin bad++; $display("FAIL lat_busy got %b want 1", ib.busy); end
    for (int e = 1; e <= 7; e++) begin
      @(negedge clk);
      expd = (e >= 1 + PB) ? 1 + (e - 1 - PB) / PB : 0;
      total++; if (ib.digit !== 4'(expd)) begin
        bad++; $display("FAIL lat_edge%0d got %0d want %0d", e, ib.digit, expd); end
    end
  endtask

  task automatic test_hold_resume;
    logic [7:0] ob;
    bit found = 0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk);
      found = (ib.digit == 4'd4);
    end
    total++; if (!found) begin bad++; $display("FAIL hold_wait4 got %0d want 4", ib.digit); end
    ib.stop = 1;
    @(negedge clk); ib.stop = 0;
    ob = {ib.digit, ib.valid, ib.busy, ib.done, ib.wrap};
    total++; if (ob !== {4'd4, 4'b1000}) begin bad++; $display("FAIL hold_enter got %h want 48", ob); end
    repeat (4) @(negedge clk);
    total++; if (ib.digit !== 4'd4 || ib.busy !== 1'b0) begin
      bad++; $display("FAIL hold_keep digit=%0d busy=%b want 4 0", ib.digit, ib.busy); end
    ib.start = 1;
    @(negedge clk); ib.start = 0;
    for (int i = 1; i <= PB; i++) begin
      @(negedge clk);
      total++; if (ib.digit !== ((i == PB) ? 4'd5 : 4'd4) || ib.busy !== 1'b1) begin
        bad++; $display("FAIL resume_edge%0d digit=%0d busy=%b want %0d 1", i, ib.digit, ib.busy,
                        (i == PB) ? 5 : 4); end
    end
  endtask

  task automatic test_load;
    logic [7:0] ob;
    ib.ld = 1; ib.ld_val = 4'd12;
    @(negedge clk); ib.ld = 0;
    total++; if (ib.digit !== 4'd0 || ib.busy !== 1'b1) begin
      bad++; $display("FAIL load_oor digit=%0d busy=%b want 0 1", ib.digit, ib.busy); end
    for (int i = 1; i <= PB + 1; i++) begin
      @(negedge clk);
      total++; if (ib.digit !== ((i == PB + 1) ? 4'd1 : 4'd0)) begin
        bad++; $display("FAIL load_restart%0d got %0d want %0d", i, ib.digit, (i == PB + 1) ? 1 : 0); end
    end
    ib.ld = 1; ib.ld_val = 4'd9;
    @(negedge clk); ib.ld = 0;
    total++; if (ib.digit !== 4'd9) begin bad++; $display("FAIL load_9 got %0d want 9", ib.digit); end
    repeat (PB) @(negedge clk);
    ib.ld = 1; ib.ld_val = 4'd7;
    @(negedge clk); ib.ld = 0;
    ob = {ib.digit, ib.valid, ib.busy, ib.done, ib.wrap};
    total++; if (ob !== {4'd7, 4'b1100}) begin bad++; $display("FAIL load_on_tick got %h want 7c", ob); end
    for (int i = 1; i <= PB + 1; i++) begin
      @(negedge clk);
      total++; if (ib.digit !== ((i == PB + 1) ? 4'd8 : 4'd7)) begin
        bad++; $display("FAIL load_after%0d got %0d want %0d", i, ib.digit, (i == PB + 1) ? 8 : 7); end
    end
  endtask

  task automatic test_async_reset;
    logic [7:0] ob;
    bit found = 0;
    for (int c = 0; c < 60 && !found; c++) begin
      @(negedge clk);
      found = (ib.digit == 4'd6);
    end
    total++; if (!found) begin bad++; $display("FAIL areset_wait6 got %0d want 6", ib.digit); end
    #2 rst = 1'b1;
    #1;
    ob = {ib.digit, ib.valid, ib.busy, ib.done, ib.wrap};
    total++; if (ob !== 8'h00) begin bad++; $display("FAIL areset_now got %h want 00", ob); end
    @(negedge clk); rst = 1'b0;
    ib.start = 1; ib.stop = 1;
    @(negedge clk); ib.start = 0; ib.stop = 0;
    total++; if (ib.valid !== 1'b0 || ib.busy !== 1'b0) begin
      bad++; $display("FAIL start_stop_idle valid=%b busy=%b want 0 0", ib.valid, ib.busy); end
    repeat (PB + 2) @(negedge clk);
    total++; if (ib.digit !== 4'd0 || ib.valid !== 1'b0) begin
      bad++; $display("FAIL idle_stays digit=%0d valid=%b want 0 0", ib.digit, ib.valid); end
  endtask

`ifdef DOWN_COUNT_EN
  task automatic test_down_count;
    logic [7:0] ob;
    int  expd;
    int  prev;
    bit  seen;
    do_reset();
    ib.start = 1;
    @(negedge clk); ib.start = 0;
    seen = 0;
    for (int c = 0; c < 200 && !seen; c++) begin @(negedge clk); seen = ib.done; end
    total++; if (!seen) begin bad++; $display("FAIL down_first_done got %b want 1", ib.done); end
    ib.dir = 1; ib.start = 1;
    @(negedge clk); ib.start = 0;
    total++; if (ib.digit !== 4'd9 || ib.busy !== 1'b1) begin
      bad++; $display("FAIL down_reload digit=%0d busy=%b want 9 1", ib.digit, ib.busy); end
    prev = 9;
    for (int k = 0; k < 19; k++) begin
      expd = (k < 9) ? 8 - k : (k == 9) ? 9 : 18 - k;
      seen = 0;
      for (int c = 0; c < 2 * PB + 2 && !seen; c++) begin @(negedge clk); seen = (ib.digit != 4'(prev)); end
      total++; if (ib.digit !== 4'(expd) || (k == 9 && ib.wrap !== 1'b1)) begin
        bad++; $display("FAIL down_step%0d digit=%0d wrap=%b want %0d", k, ib.digit, ib.wrap, expd); end
      prev = expd;
    end
    seen = 0;
    for (int c = 0; c < 2 * PB + 2 && !seen; c++) begin @(negedge clk); seen = ib.done; end
    ob = {ib.digit, ib.valid, ib.busy, ib.done, ib.wrap};
    total++; if (ob !== {4'd0, 4'b1011}) begin bad++; $display("FAIL down_done got %h want 0b", ob); end
    ib.dir = 0;
  endtask
`endif

  task automatic test_random;
    mdl_t       ma, mb;
    logic [7:0] oa, ob;
    bit         st, sp, l, d;
    int         lv;
    do_reset();
    ma = '{S_IDLE, 0, 0, 0, 1'b0};
    mb = ma;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      oa = {ia.digit, ia.valid, ia.busy, ia.done, ia.wrap};
      ob = {ib.digit, ib.valid, ib.busy, ib.done, ib.wrap};
      total++; if (oa !== mdl_out(ma)) begin
        bad++; $display("FAIL random_a cycle %0d got %h want %h", c, oa, mdl_out(ma)); end
      total++; if (ob !== mdl_out(mb)) begin
        bad++; $display("FAIL random_b cycle %0d got %h want %h", c, ob, mdl_out(mb)); end

      st = ($urandom_range(3) == 0); sp = ($urandom_range(19) == 0);
      l = ($urandom_range(29) == 0); lv = $urandom_range(15); d = 1'b0;
`ifdef DOWN_COUNT_EN
      d = 1'($urandom_range(1)); ia.dir = d;
`endif
      ia.start = st; ia.stop = sp; ia.ld = l; ia.ld_val = 4'(lv);
      ma = mdl_step(ma, st, sp, l, lv, d, PA, L, SA);

      st = ($urandom_range(3) == 0); sp = ($urandom_range(19) == 0);
      l = ($urandom_range(29) == 0); lv = $urandom_range(15); d = 1'b0;
`ifdef DOWN_COUNT_EN
      d = 1'($urandom_range(1)); ib.dir = d;
`endif
      ib.start = st; ib.stop = sp; ib.ld = l; ib.ld_val = 4'(lv);
      mb = mdl_step(mb, st, sp, l, lv, d, PB, L, SB);
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_sweep_p1();
    test_latency_p3();
    test_hold_resume();
    test_load();
    test_async_reset();
`ifdef DOWN_COUNT_EN
    test_down_count();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
